serial_pattern_tx: RTL
======================

# serial_pattern_tx

Serial bit-pattern transmitter: accepts a parallel word over a valid/ready handshake and drives it MSB-first, one bit per clock, on a single-bit serial line `x`. The word can optionally be repeated, with idle gaps between copies. It is the driving end of the single-bit `x` stream consumed by the team's sequence-detector FSMs. It replaces hand-written `#delay x=...` stimulus with synthesizable, cycle-exact pattern generation.

## Interface
Parameters:
- `WIDTH`, default 8: bits per word; must be ≥ 2.
- `GAP`, default 1: idle cycles (x=0, x_valid=0) between repeated copies; 0 allowed.

Ports:
- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  word offered.
- `in_ready`  output  1  block can accept a word.
- `in_data`  input  WIDTH  word to send; bit WIDTH-1 goes out first.
- `in_rep`  input  4  extra repeats; word is sent `in_rep`+1 times.
- `x`  output  1  serial data bit, registered.
- `x_valid`  output  1  high in every cycle `x` carries a payload or parity bit.
- `busy`  output  1  high in SHIFT and GAP states.
- `done`  output  1  one-cycle pulse after the final bit of the final copy.

## Operation
- States: IDLE, SHIFT, GAP. Encodings are 2-bit.
- IDLE:
  - `in_ready`=1. `x`=0, `x_valid`=0.
  - Handshake fires on an edge where `in_valid`&&`in_ready`.
  - On that edge, capture `in_data` into the shift register and into a hold copy, and load the repeat counter with `in_rep`.
  - On the same edge, register `x`<=`in_data[WIDTH-1]`, `x_valid`<=1, and go to SHIFT.
- SHIFT:
  - Each edge shifts left by one and presents the next bit.
  - The bit counter counts WIDTH bits, or WIDTH+1 with parity enabled.
  - After the last bit, if repeats remain and GAP>0, go to GAP.
  - If repeats remain and GAP=0, reload from the hold copy and continue SHIFT with no bubble.
  - Otherwise go to IDLE with `done`=1 for one cycle.
- GAP:
  - `x`=0, `x_valid`=0 for exactly GAP cycles.
  - Then reload from the hold copy, decrement the repeat counter, and re-enter SHIFT.
- `in_valid` outside IDLE is ignored; no capture and no error.
- `in_ready` = (state==IDLE) && !`rst`. It is the only combinational output.
- Counter widths:
  - bit counter: $clog2(WIDTH+2)
  - gap counter: $clog2(GAP+1), minimum 1
  - repeat counter: 4
- Counters never wrap. The repeat counter at 0 means this is the last copy.

## Timing
- Reset values, applied immediately when `rst` rises, including mid-word: state=IDLE, `x`=0, `x_valid`=0, `busy`=0, `done`=0, all counters 0. `in_ready`=0 while `rst` is high.
- Latency: a word accepted at edge E0 puts bit WIDTH-1 on `x` in the cycle after E0. Bit WIDTH-1-i appears after edge E0+i.
- Duration of one transfer: (rep+1)·L + rep·GAP cycles of `busy`, where L=WIDTH (WIDTH+1 with parity). `done` is asserted in the following cycle.
- On the `done` cycle the state is already IDLE and `in_ready`=1. A word presented then is accepted on that edge, so the next word starts one cycle after the previous last bit. Sustained throughput is L bits per L+1 cycles.
- `done` and a new acceptance may coincide. `done` still pulses for exactly one cycle.
- `rst` deasserting: the first handshake edge can be the first rising edge with `rst` low.

## Configuration
- Macro: `SERIAL_PATTERN_TX_PARITY_EN`.
- Defined: after the LSB of each copy, one even-parity bit (XOR of the WIDTH data bits) is sent with `x_valid`=1, so L=WIDTH+1.
- Undefined: no parity logic; L=WIDTH.

## Structure
- Shared header `seq_defs.vh` holds:
  - state encodings: `ST_IDLE`=0, `ST_SHIFT`=1, `ST_GAP`=2
  - repeat-field width (4)
  - default for the parity macro, commented out
- Sub-module `piso_shift`: a WIDTH-bit parallel-in/serial-out register with load, shift, and registered MSB output. The FSM and counters stay in `serial_pattern_tx`.

## Test plan
All cases use WIDTH=8 and GAP=2.
- Reset, then `in_data`=8'hA5, `in_rep`=0 -> `x`=1,0,1,0,0,1,0,1 in cycles 1–8 after accept with `x_valid`=1; `done` in cycle 9; `in_ready` high in cycle 9.
- `in_data`=8'h0F, `in_rep`=2 -> three copies 0000_1111 with two `x`=0/`x_valid`=0 cycles between them; `busy` for 28 cycles; single `done` in cycle 29.
- `in_data`=8'h81 accepted, `in_valid` held with 8'hFF throughout -> 8'hFF is not captured until the `done` cycle; its first bit appears the next cycle with no extra gap.
- `rst` pulsed mid-word after bit 4 of 8'hC3 -> `x`, `x_valid`, `busy` go to 0 immediately, no `done`; after release, 8'h3C is sent cleanly.
- `GAP`=0, `in_rep`=1, 8'hF0 -> 16 contiguous valid bits 1111_0000_1111_0000.
- With `SERIAL_PATTERN_TX_PARITY_EN`:
  - 8'hA5 -> 9th bit 0.
  - 8'h07 -> 9th bit 1; `done` in cycle 10.

Source files
------------

// File: rtl/serial_pattern_tx_pkg.sv
// Shared definitions for serial_pattern_tx: FSM state encodings and field widths.
// Parity is off by default; uncomment the define below (or pass it on the command line) to enable it.
package serial_pattern_tx_pkg;

  // `define SERIAL_PATTERN_TX_PARITY_EN

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int REP_W = 4;

  // Counter width that never collapses to zero bits.
  function automatic int min1_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_pattern_tx_piso_shift.sv
// Parallel-in/serial-out shift register. After a load, msb holds the bit that
// follows din[WIDTH-1], i.e. the next bit the transmitter should present.
module piso_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] sr;

  // The MSB of din goes straight to the output register in the top, so it is
  // dropped here and the register keeps only the remaining bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= {din[WIDTH-2:0], 1'b0};
    end else if (shift) begin
      sr <= {sr[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = sr[WIDTH-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial bit-pattern transmitter: sends a word MSB-first, optionally repeated with idle gaps.
// Optional even-parity bit per copy when SERIAL_PATTERN_TX_PARITY_EN is defined.
module serial_pattern_tx
  import serial_pattern_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [REP_W-1:0] in_rep,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output state_t           state_dbg
);

  // Handshake: a word transfers on a rising edge where in_valid && in_ready.
  // in_ready is high only in IDLE outside reset; in_valid is ignored otherwise.

`ifdef SERIAL_PATTERN_TX_PARITY_EN
  localparam int L = WIDTH + 1;
`else
  localparam int L = WIDTH;
`endif
  localparam int BIT_W = $clog2(WIDTH + 2);
  localparam int GAP_W = min1_clog2(GAP + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(L - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  state_t           state;
  logic [BIT_W-1:0] bit_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [REP_W-1:0] rep_cnt;
  logic [WIDTH-1:0] hold;

  logic             sr_load;
  logic             sr_shift;
  logic [WIDTH-1:0] sr_din;
  logic             sr_msb;

`ifdef SERIAL_PATTERN_TX_PARITY_EN
  logic parity;
  assign parity = ^hold;
`endif

  assign in_ready  = (state == ST_IDLE) && !rst;
  assign state_dbg = state;

  always_comb begin
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    sr_din   = hold;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          sr_load = 1'b1;
          sr_din  = in_data;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt != BIT_LAST) begin
          sr_shift = 1'b1;
        end else if ((rep_cnt != '0) && (GAP == 0)) begin
          sr_load = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          sr_load = 1'b1;
        end
      end
      default: ;
    endcase
  end

  piso_shift #(.WIDTH(WIDTH)) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (sr_load),
    .shift (sr_shift),
    .din   (sr_din),
    .msb   (sr_msb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      gap_cnt <= '0;
      rep_cnt <= '0;
      hold    <= '0;
      x       <= 1'b0;
      x_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            hold    <= in_data;
            rep_cnt <= in_rep;
            bit_cnt <= '0;
            x       <= in_data[WIDTH-1];
            x_valid <= 1'b1;
            busy    <= 1'b1;
            state   <= ST_SHIFT;
          end else begin
            x       <= 1'b0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
          end
        end

        ST_SHIFT: begin
          if (bit_cnt != BIT_LAST) begin
            bit_cnt <= bit_cnt + 1'b1;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            if (bit_cnt == BIT_W'(WIDTH - 1)) begin
              x <= parity;
            end else begin
              x <= sr_msb;
            end
`else
            x <= sr_msb;
`endif
          end else if (rep_cnt != '0) begin
            if (GAP > 0) begin
              gap_cnt <= '0;
              x       <= 1'b0;
              x_valid <= 1'b0;
              state   <= ST_GAP;
            end else begin
              // Back-to-back copy: restart from the hold copy with no bubble.
              rep_cnt <= rep_cnt - 1'b1;
              bit_cnt <= '0;
              x       <= hold[WIDTH-1];
              x_valid <= 1'b1;
            end
          end else begin
            bit_cnt <= '0;
            x       <= 1'b0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= ST_IDLE;
          end
        end

        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            rep_cnt <= rep_cnt - 1'b1;
            bit_cnt <= '0;
            x       <= hold[WIDTH-1];
            x_valid <= 1'b1;
            state   <= ST_SHIFT;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: begin
          state   <= ST_IDLE;
          x       <= 1'b0;
          x_valid <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
